// File: rtl/i2c_sensor_poller.sv
// Periodic I2C sensor poller: writes a register pointer, reads two bytes and presents them as a
// 16-bit sample behind a valid/ready handshake, with NACK/timeout retries and error accounting.
module i2c_sensor_poller #(
  parameter logic [6:0]  SENSOR_ADDR    = 7'h48,
  parameter logic [7:0]  REG_PTR        = 8'h00,
  parameter int unsigned POLL_PERIOD    = 1000,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned MAX_RETRIES    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic        err_clr,
  output logic        i2c_start,
  output logic [6:0]  i2c_slave_addr,
  output logic        i2c_rw_n,
  output logic [7:0]  i2c_wdata,
  input  logic [7:0]  i2c_rdata,
  input  logic        i2c_done,
  input  logic        i2c_ack_err,
  output logic [15:0] sample_data,
  output logic        sample_valid,
  input  logic        sample_ready,
  output logic        busy,
  output logic        err_flag,
  output logic [7:0]  err_count
);

  localparam int unsigned PW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int unsigned RW = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

  localparam logic [PW-1:0] PERIOD_LAST = PW'(POLL_PERIOD - 1);
  localparam logic [TW-1:0] TMO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX   = RW'(MAX_RETRIES);

  typedef enum logic [3:0] {
    StIdle, StWaitPeriod, StWrPtr, StWaitWr, StRdMsb, StWaitMsb, StRdLsb, StWaitLsb, StOutput,
    StFail
  } state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] period_q, period_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [7:0]    msb_q, msb_d;
  logic [15:0]   sample_q, sample_d;
  logic          err_flag_q, err_flag_d;
  logic [7:0]    err_count_q, err_count_d;
  logic          rw_n_q, rw_n_d;
  logic          err_set;

  always_comb begin
    state_d     = state_q;
    period_d    = period_q;
    tmo_d       = tmo_q;
    retry_d     = retry_q;
    msb_d       = msb_q;
    sample_d    = sample_q;
    err_count_d = err_count_q;
    err_set     = 1'b0;

    unique case (state_q)
      StIdle: if (enable) state_d = StWrPtr;
      StWaitPeriod: begin
        if (period_q == PERIOD_LAST) state_d = enable ? StWrPtr : StIdle;
        else                         period_d = period_q + 1'b1;
      end
      StWrPtr: begin
        state_d = StWaitWr;
        tmo_d   = '0;
      end
      StRdMsb: begin
        state_d = StWaitMsb;
        tmo_d   = '0;
      end
      StRdLsb: begin
        state_d = StWaitLsb;
        tmo_d   = '0;
      end
      StWaitWr, StWaitMsb, StWaitLsb: begin
        if (i2c_done && !i2c_ack_err) begin
          if (state_q == StWaitWr) begin
            state_d = StRdMsb;
          end else if (state_q == StWaitMsb) begin
            msb_d   = i2c_rdata;
            state_d = StRdLsb;
          end else begin
            // Sample register only changes on a complete read, so it holds between polls
            sample_d = {msb_q, i2c_rdata};
            state_d  = StOutput;
          end
        end else if (i2c_done || tmo_q == TMO_LAST) begin
          state_d = StFail;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      StOutput: begin
        if (sample_ready) begin
          retry_d  = '0;
          period_d = '0;
          state_d  = StWaitPeriod;
        end
      end
      StFail: begin
        if (retry_q < RETRY_MAX) begin
          retry_d = retry_q + 1'b1;
          state_d = StWrPtr;
        end else begin
          err_set  = 1'b1;
          if (err_count_q != 8'hFF) err_count_d = err_count_q + 8'd1;
          retry_d  = '0;
          period_d = '0;
          state_d  = StWaitPeriod;
        end
      end
      default: state_d = StIdle;
    endcase

    // A failure in the same cycle as err_clr keeps the flag set
    err_flag_d = err_set ? 1'b1 : (err_clr ? 1'b0 : err_flag_q);
    rw_n_d     = !(state_d inside {StWrPtr, StWaitWr});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      period_q    <= '0;
      tmo_q       <= '0;
      retry_q     <= '0;
      msb_q       <= '0;
      sample_q    <= '0;
      err_flag_q  <= 1'b0;
      err_count_q <= '0;
      rw_n_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      period_q    <= period_d;
      tmo_q       <= tmo_d;
      retry_q     <= retry_d;
      msb_q       <= msb_d;
      sample_q    <= sample_d;
      err_flag_q  <= err_flag_d;
      err_count_q <= err_count_d;
      rw_n_q      <= rw_n_d;
    end
  end

  assign i2c_start      = state_q inside {StWrPtr, StRdMsb, StRdLsb};
  assign i2c_slave_addr = SENSOR_ADDR;
  assign i2c_wdata      = REG_PTR;
  assign i2c_rw_n       = rw_n_q;
  assign sample_data    = sample_q;
  assign sample_valid   = (state_q == StOutput);
  assign busy           = !(state_q inside {StIdle, StWaitPeriod});
  assign err_flag       = err_flag_q;
  assign err_count      = err_count_q;

endmodule

// File: doc/i2c_sensor_poller.md
I2C_SENSOR_POLLER -- requirements
Module: i2c_sensor_poller

Interface
REQ-001 Parameter SENSOR_ADDR, default 7'h48: 7-bit I2C address of the polled sensor.
REQ-002 Parameter REG_PTR, default 8'h00: sensor register pointer written before each read.
REQ-003 Parameter POLL_PERIOD, default 1000: cycles from end of one poll to start of the next (min 2).
REQ-004 Parameter TIMEOUT_CYCLES, default 4096: maximum cycles waiting for i2c_done.
REQ-005 Parameter MAX_RETRIES, default 2: sequence retries after failure before giving up.
REQ-006 Ports SHALL be:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- enable  in  1  polling enable.
- err_clr  in  1  clears err_flag.
- i2c_start  out  1  one-cycle transaction request to the I2C master.
- i2c_slave_addr  out  7  transaction address.
- i2c_rw_n  out  1  1=read, 0=write.
- i2c_wdata  out  8  write byte.
- i2c_rdata  in  8  read byte from the master.
- i2c_done  in  1  one-cycle transaction completion from the master.
- i2c_ack_err  in  1  NACK indication, valid when i2c_done=1.
- sample_data  out  16  assembled sample {MSB,LSB}.
- sample_valid  out  1  sample available.
- sample_ready  in  1  downstream accepts the sample.
- busy  out  1  high in any state except IDLE and WAIT_PERIOD.
- err_flag  out  1  sticky failure flag.
- err_count  out  8  count of failed polls.

Function
REQ-007 States SHALL be IDLE, WAIT_PERIOD, WR_PTR, WAIT_WR, RD_MSB, WAIT_MSB, RD_LSB, WAIT_LSB, OUTPUT, FAIL.
REQ-008 IDLE: enable=1 -> WR_PTR next cycle; otherwise stay.
REQ-009 WR_PTR, RD_MSB and RD_LSB SHALL each last exactly one cycle, assert i2c_start=1 and then go to WAIT_WR, WAIT_MSB and WAIT_LSB respectively.
REQ-010 i2c_slave_addr SHALL equal SENSOR_ADDR at all times after reset; i2c_rw_n SHALL be 0 in WR_PTR/WAIT_WR and 1 otherwise; i2c_wdata SHALL equal REG_PTR.
REQ-011 WAIT_x with i2c_done=1 and i2c_ack_err=0: WAIT_WR -> RD_MSB; WAIT_MSB captures i2c_rdata into the MSB and goes to RD_LSB; WAIT_LSB captures the LSB and goes to OUTPUT.
REQ-012 WAIT_x with i2c_done=1 and i2c_ack_err=1, or with the timeout counter reaching TIMEOUT_CYCLES-1 and no done, SHALL go to FAIL; the timeout counter resets on entry to each WAIT_x.
REQ-013 FAIL, one cycle: if retry_cnt<MAX_RETRIES, increment retry_cnt and go to WR_PTR; else set err_flag, increment err_count (saturating at 255), clear retry_cnt and go to WAIT_PERIOD with no sample produced.
REQ-014 OUTPUT: sample_valid=1 and sample_data SHALL hold stable until sample_ready=1; on that handshake cycle clear retry_cnt and go to WAIT_PERIOD; sample_valid SHALL drop the next cycle.
REQ-015 sample_data SHALL keep its last value outside OUTPUT.
REQ-016 WAIT_PERIOD: the period counter starts at 0 on entry; when it reaches POLL_PERIOD-1, go to WR_PTR if enable=1, else to IDLE.
REQ-017 enable deasserted in any busy state SHALL NOT abort the sequence; the poll completes, including the OUTPUT handshake.
REQ-018 i2c_done received in a non-WAIT state SHALL be ignored.
REQ-019 err_clr=1 SHALL clear err_flag next cycle; when a set and err_clr occur in the same cycle, the set wins; err_count is cleared only by rst.
REQ-020 Counters SHALL be sized by $clog2 of their parameter, with no wrap inside a state.

Reset
REQ-021 rst=1 at a clock edge SHALL force IDLE, clear all counters and retry_cnt, and drive i2c_start=0, sample_valid=0, sample_data=0, err_flag=0, err_count=0, busy=0, i2c_rw_n=0, i2c_wdata=REG_PTR and i2c_slave_addr=SENSOR_ADDR; reset mid-sequence SHALL abandon it without a further i2c_start.

Verification
REQ-022 Bench parameters POLL_PERIOD=10, TIMEOUT_CYCLES=50, MAX_RETRIES=2 SHALL be used for the scenarios below.
REQ-023 Nominal: enable=1; master model returns 8'h12 then 8'h34 -> exactly three i2c_start pulses (rw_n 0,1,1), sample_data=16'h1234, sample_valid=1; with sample_ready tied high, the next WR_PTR occurs 10 cycles after the handshake.
REQ-024 Backpressure: sample_ready=0 for 20 cycles -> sample_valid and 16'h1234 stay stable, no i2c_start is issued, and the handshake completes on the first ready cycle.
REQ-025 NACK retry: ack_err=1 on the first write, then clean -> the second WR_PTR follows, a valid sample is produced, err_flag=0 and err_count=0.
REQ-026 Persistent NACK: ack_err=1 on every write -> exactly 3 write attempts, then err_flag=1, err_count=1, and no sample_valid.
REQ-027 Timeout and reset: no i2c_done for 50 cycles -> FAIL is entered (retry); asserting rst in WAIT_MSB -> IDLE next cycle with all outputs at reset values; err_clr and a failure set in the same cycle -> err_flag=1.
